// File: rtl/multdiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// funct3 opcodes, FSM state encoding, datapath width and special-case results.
package multdiv_seq_pkg;

  localparam int unsigned MD_XLEN = 32;

  localparam logic [2:0] MUL_OP    = 3'd0;
  localparam logic [2:0] MULH_OP   = 3'd1;
  localparam logic [2:0] MULHSU_OP = 3'd2;
  localparam logic [2:0] MULHU_OP  = 3'd3;
  localparam logic [2:0] DIV_OP    = 3'd4;
  localparam logic [2:0] DIVU_OP   = 3'd5;
  localparam logic [2:0] REM_OP    = 3'd6;
  localparam logic [2:0] REMU_OP   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [MD_XLEN-1:0] DIV0_Q = '1;
  localparam logic [MD_XLEN-1:0] OVF_Q  = 32'h8000_0000;

  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == MULH_OP) || (op == MULHSU_OP) || (op == DIV_OP) || (op == REM_OP);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == MULH_OP) || (op == DIV_OP) || (op == REM_OP);
  endfunction

endpackage

// File: rtl/multdiv_seq_core.sv
// Multiply/divide datapath: operand capture, one shared 33-bit add/sub stepped
// by the FSM, sign fix-up and result register. MULTDIV_RESULT_REUSE_EN adds a divide result cache.
module multdiv_seq_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            last_i,
  input  logic            inval_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            short_o,
  output logic [XLEN-1:0] result_o
);
  import multdiv_seq_pkg::*;

  logic [2:0]      op_q, op_d;
  logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            neg_a_in, neg_b_in, is_div_in, rem_sel_in, div0, ovf, special;
  logic [XLEN-1:0] abs_a_in, abs_b_in, special_res, short_res;
  logic            hit;
  logic [XLEN-1:0] hit_res;

  assign neg_a_in   = op_signed_a(op_i) & operand_a_i[XLEN-1];
  assign neg_b_in   = op_signed_b(op_i) & operand_b_i[XLEN-1];
  assign abs_a_in   = neg_a_in ? -operand_a_i : operand_a_i;
  assign abs_b_in   = neg_b_in ? -operand_b_i : operand_b_i;
  assign is_div_in  = op_i[2];
  assign rem_sel_in = op_i[1];
  assign div0       = is_div_in && (operand_b_i == '0);
  assign ovf        = is_div_in && !op_i[0] && (operand_a_i == OVF_Q) && (operand_b_i == '1);
  assign special    = div0 | ovf;
  assign special_res = div0 ? (rem_sel_in ? operand_a_i : DIV0_Q)
                            : (rem_sel_in ? '0 : OVF_Q);
  assign short_res  = special ? special_res : hit_res;
  assign short_o    = special | hit;

  // Divide: {hi,lo[msb]} - divisor, borrow-free carry-out means remainder >= divisor.
  logic [XLEN:0]   add_x, add_y;
  logic            add_cin;
  logic [XLEN+1:0] add_sum;
  logic            div_ge;

  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (op_q[2]) begin
      add_x   = {hi_q, lo_q[XLEN-1]};
      add_y   = ~{1'b0, mcand_q};
      add_cin = 1'b1;
    end else begin
      add_x = {1'b0, hi_q};
      add_y = lo_q[0] ? {1'b0, mcand_q} : '0;
    end
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(XLEN+1){1'b0}}, add_cin};
  assign div_ge  = add_sum[XLEN+1];

  logic [XLEN-1:0]   hi_step, lo_step;
  logic [2*XLEN-1:0] product, prod_fin;
  logic [XLEN-1:0]   quo_fin, rem_fin, fin_res;
  logic              sign_diff;

  always_comb begin
    if (op_q[2]) begin
      hi_step = div_ge ? add_sum[XLEN-1:0] : add_x[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_step = add_sum[XLEN:1];
      lo_step = {add_sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign sign_diff = neg_a_q ^ neg_b_q;
  assign product   = {hi_step, lo_step};
  assign prod_fin  = sign_diff ? -product : product;
  assign quo_fin   = sign_diff ? -lo_step : lo_step;
  assign rem_fin   = neg_a_q ? -hi_step : hi_step;

  always_comb begin
    if (op_q[2])              fin_res = op_q[1] ? rem_fin : quo_fin;
    else if (op_q == MUL_OP)  fin_res = prod_fin[XLEN-1:0];
    else                      fin_res = prod_fin[2*XLEN-1:XLEN];
  end

  always_comb begin
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    if (start_i) begin
      op_d    = op_i;
      neg_a_d = neg_a_in;
      neg_b_d = neg_b_in;
      mcand_d = abs_b_in;
      hi_d    = '0;
      lo_d    = abs_a_in;
      if (short_o) result_d = short_res;
    end else if (step_i) begin
      hi_d = hi_step;
      lo_d = lo_step;
      if (last_i) result_d = fin_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

`ifdef MULTDIV_RESULT_REUSE_EN
  logic            c_valid_q, c_signed_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_quo_q, c_rem_q;

  assign hit = is_div_in && c_valid_q && (c_signed_q == !op_i[0])
            && (operand_a_i == c_a_q) && (operand_b_i == c_b_q);
  assign hit_res = rem_sel_in ? c_rem_q : c_quo_q;

  // Tags are captured at start with valid cleared; the entry only becomes valid on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid_q  <= 1'b0;
      c_signed_q <= 1'b0;
      c_a_q      <= '0;
      c_b_q      <= '0;
      c_quo_q    <= '0;
      c_rem_q    <= '0;
    end else if (inval_i) begin
      c_valid_q <= 1'b0;
    end else if (start_i && is_div_in && !short_o) begin
      c_valid_q  <= 1'b0;
      c_signed_q <= !op_i[0];
      c_a_q      <= operand_a_i;
      c_b_q      <= operand_b_i;
    end else if (step_i && last_i && op_q[2]) begin
      c_valid_q <= 1'b1;
      c_quo_q   <= quo_fin;
      c_rem_q   <= rem_fin;
    end
  end
`else
  logic unused_inval;
  assign unused_inval = inval_i;
  assign hit          = 1'b0;
  assign hit_res      = '0;
`endif

endmodule

// File: rtl/multdiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage: IDLE/CALC/DONE FSM
// driving multdiv_seq_core. Optional divide result reuse: MULTDIV_RESULT_REUSE_EN.
module multdiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic            ex_hold_i,
  input  logic            flush_i,
  output logic            hold_flag_o,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            busy_o
);
  import multdiv_seq_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start, step, last, inval, short_path;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    inval   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && !flush_i) begin
          start = 1'b1;
          cnt_d = '0;
          state_d = short_path ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush_i) begin
          inval   = 1'b1;
          state_d = IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            last    = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (flush_i || !ex_hold_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  multdiv_seq_core #(.XLEN(XLEN)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .step_i     (step),
    .last_i     (last),
    .inval_i    (inval),
    .op_i       (op_i),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .short_o    (short_path),
    .result_o   (result_o)
  );

  // Gated by rst_n so every output reads 0 while reset is held.
  assign hold_flag_o = rst_n && !flush_i &&
                       (((state_q == IDLE) && en_i) || (state_q == CALC));
  assign done_o      = (state_q == DONE) && !flush_i;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq (expects MULTDIV_RESULT_REUSE_EN
// to match the RTL build when defined).
module tb_multdiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i, ex_hold_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic        hold_flag_o, done_o, busy_o;
  logic [31:0] result_o;

  int vectors = 0;
  int miscompares = 0;

`ifdef MULTDIV_RESULT_REUSE_EN
  localparam int REUSE_HOLDS = 1;
`else
  localparam int REUSE_HOLDS = 33;
`endif

  always #5 clk = ~clk;

  multdiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .op_i       (op_i),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .ex_hold_i  (ex_hold_i),
    .flush_i    (flush_i),
    .hold_flag_o(hold_flag_o),
    .result_o   (result_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_hold, input string tag);
    int holds;
    bit seen;
    holds = 0;
    seen  = 1'b0;
    @(posedge clk); #1;
    op_i = op; operand_a_i = a; operand_b_i = b; en_i = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
      else begin
        if (hold_flag_o) holds++;
        if (i == 1) begin
          operand_a_i = $urandom;
          operand_b_i = $urandom;
        end
      end
    end
    check({tag, " done"}, 32'(seen), 32'd1);
    check({tag, " holds"}, 32'(holds), 32'(exp_hold));
    check({tag, " result"}, result_o, exp_r);
    check({tag, " hold_in_done"}, 32'(hold_flag_o), 32'd0);
    en_i = 1'b0;
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(done_o), 32'd0);
    check({tag, " idle_after"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    bit seen;
    rst_n = 1'b0; en_i = 1'b0; ex_hold_i = 1'b0; flush_i = 1'b0;
    op_i = 3'd0; operand_a_i = '0; operand_b_i = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst result", result_o, 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst hold", 32'(hold_flag_o), 32'd0);
    rst_n = 1'b1;

    // Multiplies
    run_op(3'd0, 32'd7, 32'd6, 32'h0000_002A, 33, "MUL 7x6");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "MULH -1x-1");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU");
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 33, "MUL -3x5");

    // Divides
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "DIV -7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, REUSE_HOLDS, "REM -7/2");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "DIVU 100/7");

    // Special cases
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIVU 5/0");
    run_op(3'd7, 32'd9, 32'd0, 32'd9, 1, "REMU 9/0");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "REM ovf");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV ovf");

    // Flush in CALC at cnt=10
    @(posedge clk); #1;
    op_i = 3'd0; operand_a_i = 32'd1234; operand_b_i = 32'd5678; en_i = 1'b1;
    @(posedge clk); #1;
    en_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    check("flush hold", 32'(hold_flag_o), 32'd0);
    check("flush done", 32'(done_o), 32'd0);
    check("flush busy_calc", 32'(busy_o), 32'd1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) check("flush idle", 32'(busy_o), 32'd0);
      if (done_o) dn++;
    end
    check("flush no_done", 32'(dn), 32'd0);
    run_op(3'd0, 32'd3, 32'd3, 32'd9, 33, "MUL 3x3");

    // en and flush together in IDLE
    @(posedge clk); #1;
    op_i = 3'd0; operand_a_i = 32'd2; operand_b_i = 32'd2; en_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    check("enflush hold", 32'(hold_flag_o), 32'd0);
    @(posedge clk); #1;
    en_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check("enflush idle", 32'(busy_o), 32'd0);

    // ex_hold on entry to DONE
    @(posedge clk); #1;
    op_i = 3'd0; operand_a_i = 32'd5; operand_b_i = 32'd5; en_i = 1'b1; ex_hold_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("exhold reach_done", 32'(seen), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) begin
        ex_hold_i = 1'b0;
        en_i = 1'b0;
      end
      check($sformatf("exhold done%0d", k), 32'(done_o), 32'd1);
      check($sformatf("exhold result%0d", k), result_o, 32'd25);
      check($sformatf("exhold hold%0d", k), 32'(hold_flag_o), 32'd0);
    end
    @(negedge clk);
    check("exhold released", 32'(done_o), 32'd0);
    check("exhold idle", 32'(busy_o), 32'd0);

    // Divide reuse pair
    run_op(3'd4, 32'd100, 32'd7, 32'd14, 33, "DIV 100/7");
    run_op(3'd6, 32'd100, 32'd7, 32'd2, REUSE_HOLDS, "REM 100/7");

    // Reset mid-operation
    @(posedge clk); #1;
    op_i = 3'd4; operand_a_i = 32'd1000; operand_b_i = 32'd3; en_i = 1'b1;
    @(posedge clk); #1;
    en_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst done", 32'(done_o), 32'd0);
    check("midrst hold", 32'(hold_flag_o), 32'd0);
    check("midrst result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd5, 32'd1000, 32'd3, 32'd333, 33, "DIVU 1000/3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
